// File: rtl/multiword_add_seq_pkg.sv
// Shared definitions for the sequential multiword adder: FSM states and
// a sizing helper for the word index register.
package multiword_add_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Word index width; never narrower than one bit.
    function automatic int idx_width(input int words);
        return (words > 2) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/multiword_add_seq_if.sv
// Request/result bundle of the sequential multiword adder.
interface multiword_add_seq_if #(
    parameter int WIDTH = 4,
    parameter int WORDS = 4
);
    logic                   start;
    logic                   sub;
    logic                   cin;
    logic [WIDTH*WORDS-1:0] a;
    logic [WIDTH*WORDS-1:0] b;
    logic                   ready;
    logic                   done;
    logic [WIDTH*WORDS-1:0] sum;
    logic                   cout;

    modport master (
        output start, sub, cin, a, b,
        input  ready, done, sum, cout
    );

    modport slave (
        input  start, sub, cin, a, b,
        output ready, done, sum, cout
    );
endinterface

// File: rtl/multiword_add_seq_rca.sv
// WIDTH-bit ripple-carry adder slice shared by every word of the operation.
module ripple_carry_adder #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic [WIDTH-1:0] s,
    output logic             co
);

    // Bit-serial carry chain; carry held in a scalar to keep the chain flat.
    always_comb begin
        logic cc;
        cc = ci;
        s  = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            s[i] = a[i] ^ b[i] ^ cc;
            cc   = (a[i] & b[i]) | (cc & (a[i] ^ b[i]));
        end
        co = cc;
    end

endmodule

// File: rtl/multiword_add_seq.sv
// Sequential multiword adder/subtractor: one WIDTH-bit adder slice is reused
// for WORDS cycles, carrying between words through a single carry register.
import multiword_add_seq_pkg::*;

module multiword_add_seq #(
    parameter int WIDTH = 4,
    parameter int WORDS = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    multiword_add_seq_if.slave bus
);

    localparam int IDXW  = idx_width(WORDS);
    localparam int TOTAL = WIDTH * WORDS;

    state_t            state;
    state_t            state_nx;
    logic [IDXW-1:0]   idx;
    logic              carry;
    logic              sub_q;
    logic              cout_q;
    logic [TOTAL-1:0]  a_q;
    logic [TOTAL-1:0]  b_q;
    logic [TOTAL-1:0]  sum_q;

    logic              ready_c;
    logic              done_c;
    logic              accept;
    logic              last;
    logic [WIDTH-1:0]  a_w;
    logic [WIDTH-1:0]  b_w;
    logic [WIDTH-1:0]  s_w;
    logic              co_w;

    assign last = (idx == IDXW'(WORDS - 1));

    // Select the current word; B is inverted for subtraction (A + ~B + 1).
    always_comb begin
        a_w = a_q[idx*WIDTH +: WIDTH];
        b_w = b_q[idx*WIDTH +: WIDTH] ^ {WIDTH{sub_q}};
    end

    ripple_carry_adder #(.WIDTH(WIDTH)) u_rca (
        .a  (a_w),
        .b  (b_w),
        .ci (carry),
        .s  (s_w),
        .co (co_w)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    // Next state and state-decoded outputs; done/ready depend on state only.
    always_comb begin
        state_nx = state;
        ready_c  = 1'b0;
        done_c   = 1'b0;
        accept   = 1'b0;
        case (state)
            S_IDLE: begin
                ready_c = 1'b1;
                if (bus.start) begin
                    accept   = 1'b1;
                    state_nx = S_RUN;
                end
            end
            S_RUN: begin
                if (last) state_nx = S_DONE;
            end
            S_DONE: begin
                done_c   = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Operand capture on accept, then one result word per RUN cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            sub_q  <= 1'b0;
            idx    <= '0;
            carry  <= 1'b0;
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else if (accept) begin
            a_q    <= bus.a;
            b_q    <= bus.b;
            sub_q  <= bus.sub;
            idx    <= '0;
            carry  <= bus.sub | bus.cin;
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else if (state == S_RUN) begin
            sum_q[idx*WIDTH +: WIDTH] <= s_w;
            carry                     <= co_w;
            if (last) cout_q <= co_w;
            else      idx    <= idx + 1'b1;
        end
    end

    assign bus.ready = ready_c;
    assign bus.done  = done_c;
    assign bus.sum   = sum_q;
    assign bus.cout  = cout_q;

endmodule

// File: tb/tb_multiword_add_seq.sv
// Self-checking bench for multiword_add_seq: directed cases, random
// operations, start spam, mid-run reset, and an exhaustive small config.
module tb_multiword_add_seq;

    localparam int W  = 4;
    localparam int N  = 4;
    localparam int W2 = 2;
    localparam int N2 = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    multiword_add_seq_if #(.WIDTH(W),  .WORDS(N))  bus4 ();
    multiword_add_seq_if #(.WIDTH(W2), .WORDS(N2)) bus2 ();

    multiword_add_seq #(.WIDTH(W), .WORDS(N)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4.slave)
    );

    multiword_add_seq #(.WIDTH(W2), .WORDS(N2)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2.slave)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: {cout,sum} = A + B + cin or A + ~B + 1, modulo 2^(bits+1).
    function automatic logic [63:0] ref_model(input int bits, input logic [63:0] a,
                                              input logic [63:0] b, input logic sub,
                                              input logic cin);
        logic [63:0] mask;
        logic [63:0] bb;
        mask = (64'd1 << bits) - 64'd1;
        bb   = sub ? (~b & mask) : (b & mask);
        return ((a & mask) + bb + (sub ? 64'd1 : {63'd0, cin})) & ((mask << 1) | 64'd1);
    endfunction

    // One operation on the 4x4 instance; operands are scrambled while running.
    task automatic run4(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic sub, input logic cin, output logic [63:0] res);
        int lat;
        logic got;
        logic [63:0] exp;
        exp = ref_model(W*N, 64'(a), 64'(b), sub, cin);
        bus4.a = a; bus4.b = b; bus4.sub = sub; bus4.cin = cin; bus4.start = 1'b1;
        @(posedge clk); #1;
        bus4.start = 1'b0;
        lat = 0; got = 1'b0;
        while (lat < 20 && !got) begin
            bus4.a = 16'($urandom); bus4.b = 16'($urandom);
            bus4.sub = 1'($urandom); bus4.cin = 1'($urandom);
            @(posedge clk); #1;
            lat++;
            got = bus4.done;
        end
        res = 64'({bus4.cout, bus4.sum});
        check({tag, "_latency"}, 64'(lat), 64'(N));
        check({tag, "_result"}, res, exp);
        check({tag, "_ready_in_done"}, 64'(bus4.ready), 64'd0);
        @(posedge clk); #1;
        check({tag, "_ready_after"}, 64'(bus4.ready), 64'd1);
        check({tag, "_hold"}, 64'({bus4.cout, bus4.sum}), exp);
    endtask

    // One operation on the 2x2 instance.
    task automatic run2(input logic [3:0] a, input logic [3:0] b,
                        input logic sub, input logic cin);
        int lat;
        logic got;
        logic [63:0] exp;
        exp = ref_model(W2*N2, 64'(a), 64'(b), sub, cin);
        bus2.a = a; bus2.b = b; bus2.sub = sub; bus2.cin = cin; bus2.start = 1'b1;
        @(posedge clk); #1;
        bus2.start = 1'b0;
        lat = 0; got = 1'b0;
        while (lat < 20 && !got) begin
            @(posedge clk); #1;
            lat++;
            got = bus2.done;
        end
        check($sformatf("exh_lat_s%0d_c%0d_b%0h_a%0h", sub, cin, b, a), 64'(lat), 64'(N2));
        check($sformatf("exh_res_s%0d_c%0d_b%0h_a%0h", sub, cin, b, a),
              64'({bus2.cout, bus2.sum}), exp);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [63:0] res;
        logic [15:0] ra, rb;
        logic [15:0] opa [16];
        logic [15:0] opb [16];
        logic        ops [16];
        logic        opc [16];
        int          ndone;
        int          first_edge;
        int          second_edge;

        bus4.start = 1'b0; bus4.sub = 1'b0; bus4.cin = 1'b0; bus4.a = '0; bus4.b = '0;
        bus2.start = 1'b0; bus2.sub = 1'b0; bus2.cin = 1'b0; bus2.a = '0; bus2.b = '0;

        // Reset state.
        #3;
        check("rst_ready", 64'(bus4.ready), 64'd1);
        check("rst_done",  64'(bus4.done),  64'd0);
        check("rst_sum",   64'(bus4.sum),   64'd0);
        check("rst_cout",  64'(bus4.cout),  64'd0);
        check("rst2_ready", 64'(bus2.ready), 64'd1);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        // Directed cases (first start right after reset release).
        run4("carry_chain", 16'hFFFF, 16'h0001, 1'b0, 1'b0, res);
        check("carry_chain_const", res, 64'h10000);
        run4("sub_noborrow", 16'h1234, 16'h0235, 1'b1, 1'b0, res);
        check("sub_noborrow_const", res, 64'h0FFF | 64'h10000);
        run4("sub_borrow", 16'h0001, 16'h0002, 1'b1, 1'b1, res);
        check("sub_borrow_const", res, 64'h0FFFF);
        run4("cin_add", 16'h7FFF, 16'h0000, 1'b0, 1'b1, res);
        check("cin_add_const", res, 64'h08000);

        // Random operations.
        for (int i = 0; i < 24; i++) begin
            ra = 16'($urandom); rb = 16'($urandom);
            run4($sformatf("rand%0d", i), ra, rb, 1'($urandom), 1'($urandom), res);
        end

        // Start held high for 12 cycles: accepts only at edges 0 and 6.
        ndone = 0; first_edge = -1; second_edge = -1;
        for (int i = 0; i < 16; i++) begin
            opa[i] = 16'($urandom); opb[i] = 16'($urandom);
            ops[i] = 1'($urandom);  opc[i] = 1'($urandom);
            bus4.a = opa[i]; bus4.b = opb[i]; bus4.sub = ops[i]; bus4.cin = opc[i];
            bus4.start = (i < 12);
            @(posedge clk); #1;
            if (bus4.done) begin
                if (ndone == 0) begin
                    first_edge = i;
                    check("spam_res0", 64'({bus4.cout, bus4.sum}),
                          ref_model(W*N, 64'(opa[0]), 64'(opb[0]), ops[0], opc[0]));
                end else if (ndone == 1) begin
                    second_edge = i;
                    check("spam_res1", 64'({bus4.cout, bus4.sum}),
                          ref_model(W*N, 64'(opa[6]), 64'(opb[6]), ops[6], opc[6]));
                end
                ndone++;
            end
        end
        bus4.start = 1'b0;
        check("spam_ndone", 64'(ndone), 64'd2);
        check("spam_first", 64'(first_edge), 64'(N));
        check("spam_gap", 64'(second_edge - first_edge), 64'(N + 2));

        // Reset asserted once idx has reached 2.
        bus4.a = 16'hABCD; bus4.b = 16'h1357; bus4.sub = 1'b0; bus4.cin = 1'b1;
        bus4.start = 1'b1;
        @(posedge clk); #1;
        bus4.start = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midrst_sum",   64'(bus4.sum),   64'd0);
        check("midrst_cout",  64'(bus4.cout),  64'd0);
        check("midrst_ready", 64'(bus4.ready), 64'd1);
        check("midrst_done",  64'(bus4.done),  64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (bus4.done) ndone++;
        end
        check("midrst_no_done", 64'(ndone), 64'd0);
        run4("after_rst", 16'hABCD, 16'h1357, 1'b0, 1'b1, res);
        check("after_rst_const", res, 64'h0BF25);

        // Exhaustive 2x2 sweep over {sub, cin, b, a}.
        for (int v = 0; v < 64; v++) begin
            run2(4'(v), 4'(v >> 4 & 3 | 0) , 1'b0, 1'b0);
        end
        for (int s = 0; s < 2; s++)
            for (int c = 0; c < 2; c++)
                for (int bv = 0; bv < 16; bv++)
                    for (int av = 0; av < 16; av++)
                        run2(4'(av), 4'(bv), 1'(s), 1'(c));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global watchdog so the bench always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/multiword_add_seq.md
MULTIWORD_ADD_SEQ -- requirements
Module: multiword_add_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4: bit width of the single shared adder slice.
REQ-002 The block SHALL have parameter WORDS, default 4, minimum 2: number of WIDTH-bit words per operand.
REQ-003 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 Port start, input, 1: request a new operation; sampled only while ready=1.
REQ-006 Port sub, input, 1: 0 = A+B+cin, 1 = A-B; sampled with start.
REQ-007 Port cin, input, 1: carry-in for add; ignored when sub=1.
REQ-008 Port a, input, WIDTH*WORDS: operand A, word 0 = LSBs.
REQ-009 Port b, input, WIDTH*WORDS: operand B, word 0 = LSBs.
REQ-010 Port ready, output, 1: high only in IDLE.
REQ-011 Port done, output, 1: one-cycle pulse; result valid.
REQ-012 Port sum, output, WIDTH*WORDS: result register.
REQ-013 Port cout, output, 1: final carry; for sub, 1 = no borrow.

Function
REQ-014 The block SHALL use a three-state FSM: IDLE, RUN, DONE.
REQ-015 IDLE with start=1 at an edge SHALL latch a, b, and sub; set word index to 0; load the carry register with (sub ? 1 : cin); clear sum; and enter RUN.
REQ-016 Each RUN edge SHALL feed word[idx] of A and word[idx] of B (B inverted when sub=1), plus the carry register, into one WIDTH-bit adder.
REQ-017 On that same RUN edge, the adder sum SHALL be written to sum word[idx], the adder carry-out SHALL be written to the carry register, and idx SHALL increment.
REQ-018 RUN SHALL enter DONE on the edge that processes idx = WORDS-1, and idx SHALL not wrap.
REQ-019 In DONE, done SHALL be 1 and cout SHALL equal the carry register; the next edge SHALL return to IDLE unconditionally.
REQ-020 Latency SHALL be exactly WORDS cycles from the accepting edge to the first cycle with done=1, and exactly WORDS+2 edges from one accepted start to the next accepted start.
REQ-021 start while ready=0 (RUN or DONE) SHALL be ignored and SHALL NOT be queued.
REQ-022 Input changes after the accepting edge SHALL NOT affect the result.
REQ-023 sum and cout SHALL hold their values after DONE until the next accepted start.
REQ-024 {cout,sum} SHALL equal A+B+cin (sub=0) or A+~B+1 (sub=1), modulo 2^(WIDTH*WORDS+1).
REQ-025 done SHALL be driven from state only, with no combinational path from any input.

Reset
REQ-026 While rst_n=0, the block SHALL force state=IDLE, idx=0, carry=0, sum=0, cout=0, done=0, and ready=1, regardless of clk.
REQ-027 Reset asserted mid-RUN or in DONE SHALL abort the operation; no done pulse SHALL follow.
REQ-028 The first start SHALL be accepted on the first clk edge after rst_n rises.

Structure
REQ-029 The FSM state encodings SHALL be in a shared package as constants, not duplicated locally.
REQ-030 The block SHALL instantiate exactly one existing ripple_carry_adder #(WIDTH) sub-module as its arithmetic datapath.
REQ-031 The block SHALL contain no other adders, so that WORDS-level carry propagation happens only through the carry register.

Verification
REQ-032 WIDTH=4, WORDS=4: a=0xFFFF, b=0x0001, sub=0, cin=0 -> done 4 cycles after start, sum=0x0000, cout=1.
REQ-033 a=0x1234, b=0x0235, sub=1 -> sum=0x0FFF, cout=1; then a=0x0001, b=0x0002, sub=1 -> sum=0xFFFF, cout=0.
REQ-034 Start pulsed every cycle for 12 cycles -> exactly two done pulses, 6 edges apart; operands changed during RUN do not alter sum.
REQ-035 rst_n low for one cycle at RUN idx=2 -> sum=0, cout=0, ready=1, no done pulse; the next start completes normally.
REQ-036 Exhaustive WIDTH=2, WORDS=2 over all {sub,cin,b,a} -> {cout,sum} matches the REQ-024 reference and latency is 2 on every vector.
